// File: rtl/data_out_stream.sv
// Avalon-MM fed sample FIFO with first-word fall-through output, low-watermark
// and optional overflow interrupts (overflow logic built only with DATA_OUT_STREAM_OVERFLOW_EN).
module data_out_stream #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [DATA_W-1:0] out_port,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              irq
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d, thresh_q, thresh_d;
    logic [31:0]       readdata_q, readdata_d;
    logic              lw_mask_q, lw_mask_d;
    logic              lw_ev_q, lw_ev_d;
    logic              above_q, above_d;
    logic              ovf_mask, ovf_ev;

    logic wr, full, empty, flush, push_req, push, pop, drop, ev_clear, lw_set;
    logic unused_wd;

    assign unused_wd = ^writedata;

    assign wr       = chipselect & ~write_n;
    assign full     = (level_q == LW'(DEPTH));
    assign empty    = (level_q == '0);
    assign flush    = wr && (address == 2'd1) && writedata[2];
    assign push_req = wr && (address == 2'd0);
    assign push     = push_req && !full && !flush;
    assign pop      = !empty && out_ready && !flush;
    assign drop     = push_req && full;
    assign ev_clear = wr && (address == 2'd3);

    // Low-water fires on the first cycle after the level drops to/below the threshold.
    assign above_d  = (level_q > thresh_q);
    assign lw_set   = above_q && !above_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            level_d = level_q + LW'(push) - LW'(pop);
        end
    end

    always_comb begin
        lw_mask_d = lw_mask_q;
        thresh_d  = thresh_q;
        lw_ev_d   = lw_ev_q | lw_set;
        if (wr && address == 2'd1) lw_mask_d = writedata[0];
        if (wr && address == 2'd2) thresh_d  = writedata[LW-1:0];
        if (ev_clear)              lw_ev_d   = 1'b0;
    end

    always_comb begin
        readdata_d = '0;
        unique case (address)
            2'd0: begin
                readdata_d[8 +: LW] = level_q;
                readdata_d[1]       = full;
                readdata_d[0]       = empty;
            end
            2'd1:    readdata_d[1:0] = {ovf_mask, lw_mask_q};
            2'd2:    readdata_d[LW-1:0] = thresh_q;
            default: readdata_d[1:0] = {ovf_ev, lw_ev_q};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            thresh_q   <= '0;
            readdata_q <= '0;
            lw_mask_q  <= 1'b0;
            lw_ev_q    <= 1'b0;
            above_q    <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            thresh_q   <= thresh_d;
            readdata_q <= readdata_d;
            lw_mask_q  <= lw_mask_d;
            lw_ev_q    <= lw_ev_d;
            above_q    <= above_d;
        end
    end

    // Storage is not reset; empty/level gate everything that reads it.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= writedata[DATA_W-1:0];
    end

`ifdef DATA_OUT_STREAM_OVERFLOW_EN
    logic ovf_mask_q, ovf_ev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_mask_q <= 1'b0;
            ovf_ev_q   <= 1'b0;
        end else begin
            if (wr && address == 2'd1) ovf_mask_q <= writedata[1];
            if (ev_clear)              ovf_ev_q   <= 1'b0;
            else if (drop)             ovf_ev_q   <= 1'b1;
        end
    end

    assign ovf_mask = ovf_mask_q;
    assign ovf_ev   = ovf_ev_q;
`else
    logic unused_drop;
    assign unused_drop = drop;
    assign ovf_mask    = 1'b0;
    assign ovf_ev      = 1'b0;
`endif

    assign readdata  = readdata_q;
    assign out_valid = !empty;
    assign out_port  = empty ? '0 : mem_q[rd_ptr_q];
    assign irq       = (lw_ev_q & lw_mask_q) | (ovf_ev & ovf_mask);

endmodule

// File: tb/tb_data_out_stream.sv
// Randomised and directed bench for data_out_stream against a queue-based model.
module tb_data_out_stream;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 16;
`ifdef DATA_OUT_STREAM_OVERFLOW_EN
    localparam bit OVF = 1'b1;
`else
    localparam bit OVF = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [1:0]        address = '0;
    logic              chipselect = 1'b0;
    logic              write_n = 1'b1;
    logic [31:0]       writedata = '0;
    logic [31:0]       readdata;
    logic [DATA_W-1:0] out_port;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              irq;

    int errors = 0;
    int checks = 0;

    logic [DATA_W-1:0] mq[$];
    int                m_thr = 0;
    bit                m_lwm = 0, m_ovm = 0, m_lwe = 0, m_ove = 0, m_prev_above = 0;
    logic [31:0]       m_rd = '0;

    data_out_stream #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .out_port(out_port), .out_valid(out_valid), .out_ready(out_ready), .irq(irq)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] exp_port();
        return (mq.size() != 0) ? mq[0] : '0;
    endfunction

    function automatic logic exp_irq();
        return (m_lwe & m_lwm) | (m_ove & m_ovm);
    endfunction

    // Applies the current inputs to the model, then advances one clock.
    task automatic step();
        bit wr;
        int lvl;
        bit lw_set, drop;
        wr  = chipselect && !write_n;
        lvl = mq.size();
        if (reset) begin
            mq.delete();
            m_thr = 0; m_lwm = 0; m_ovm = 0; m_lwe = 0; m_ove = 0;
            m_prev_above = 0; m_rd = '0;
        end else begin
            case (address)
                2'd0:    m_rd = (lvl << 8) | ((lvl == DEPTH) ? 2 : 0) | ((lvl == 0) ? 1 : 0);
                2'd1:    m_rd = {30'd0, m_ovm, m_lwm};
                2'd2:    m_rd = m_thr;
                default: m_rd = {30'd0, m_ove, m_lwe};
            endcase
            lw_set = m_prev_above && !(lvl > m_thr);
            m_prev_above = (lvl > m_thr);
            if (lw_set) m_lwe = 1;
            drop = 0;
            if (wr && address == 2'd1 && writedata[2]) begin
                mq.delete();
            end else begin
                if (lvl > 0 && out_ready) void'(mq.pop_front());
                if (wr && address == 2'd0) begin
                    if (lvl == DEPTH) drop = 1;
                    else mq.push_back(writedata[DATA_W-1:0]);
                end
            end
            if (OVF && drop) m_ove = 1;
            if (wr && address == 2'd1) begin
                m_lwm = writedata[0];
                m_ovm = OVF ? writedata[1] : 1'b0;
            end
            if (wr && address == 2'd2) m_thr = writedata[4:0];
            if (wr && address == 2'd3) begin
                m_lwe = 0;
                m_ove = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        step();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a);
        address = a;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", irq); end
        checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL reset_readdata got=%h exp=0", readdata); end
        checks++; if (out_port !== '0) begin errors++; $display("FAIL reset_port got=%h exp=0", out_port); end
        bus_read(2'd0);
        checks++; if (readdata !== 32'h1) begin errors++; $display("FAIL reset_status got=%h exp=1", readdata); end
    endtask

    task automatic test_push_basic();
        out_ready = 1'b0;
        address = 2'd0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pre_push_valid got=%b exp=0", out_valid); end
        bus_write(2'd0, 32'h0000_1234);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL push_valid got=%b exp=1", out_valid); end
        checks++; if (out_port !== 16'h1234) begin errors++; $display("FAIL push_port got=%h exp=1234", out_port); end
        bus_read(2'd0);
        checks++; if (readdata !== 32'h100) begin errors++; $display("FAIL push_status got=%h exp=100", readdata); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 15; i++) bus_write(2'd0, $urandom);
        bus_write(2'd0, 32'h0000_DEAD);
        bus_read(2'd0);
        checks++; if (readdata !== 32'h1002) begin errors++; $display("FAIL full_status got=%h exp=1002", readdata); end
        bus_write(2'd1, 32'h2);
        checks++; if (irq !== OVF) begin errors++; $display("FAIL ovf_irq got=%b exp=%b", irq, OVF); end
        bus_read(2'd3);
        checks++; if (readdata !== {30'd0, OVF, 1'b0}) begin errors++; $display("FAIL ovf_event got=%h exp=%h", readdata, {30'd0, OVF, 1'b0}); end
        bus_read(2'd1);
        checks++; if (readdata !== {30'd0, OVF, 1'b0}) begin errors++; $display("FAIL ovf_mask got=%h exp=%h", readdata, {30'd0, OVF, 1'b0}); end
        out_ready = 1'b1;
        for (int i = 0; i < 40 && mq.size() != 0; i++) begin
            checks++; if (out_port !== exp_port()) begin errors++; $display("FAIL drain_port got=%h exp=%h", out_port, exp_port()); end
            step();
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got=%b exp=0", out_valid); end
        out_ready = 1'b0;
        bus_write(2'd1, 32'h0);
        bus_write(2'd3, 32'h0);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL full_irq_clear got=%b exp=0", irq); end
    endtask

    task automatic test_lowwater();
        bit fired;
        out_ready = 1'b0;
        bus_write(2'd2, 32'd4);
        bus_write(2'd1, 32'h1);
        for (int i = 0; i < 6; i++) bus_write(2'd0, $urandom);
        bus_write(2'd3, 32'h0);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL lw_pre_irq got=%b exp=0", irq); end
        out_ready = 1'b1;
        fired = 0;
        for (int i = 0; i < 10 && !fired; i++) begin
            checks++; if (irq !== exp_irq()) begin errors++; $display("FAIL lw_irq got=%b exp=%b", irq, exp_irq()); end
            if (irq === 1'b1) fired = 1;
            else step();
        end
        out_ready = 1'b0;
        checks++; if (fired !== 1'b1) begin errors++; $display("FAIL lw_timeout got=%b exp=1", fired); end
        bus_read(2'd3);
        checks++; if (readdata !== m_rd) begin errors++; $display("FAIL lw_event got=%h exp=%h", readdata, m_rd); end
        bus_write(2'd3, 32'h0);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL lw_clear got=%b exp=0", irq); end
        out_ready = 1'b1;
        for (int i = 0; i < 20 && mq.size() != 0; i++) step();
        out_ready = 1'b0;
        bus_write(2'd1, 32'h0);
        bus_write(2'd2, 32'h0);
        bus_write(2'd3, 32'h0);
    endtask

    task automatic test_wrap();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) bus_write(2'd0, $urandom);
        chipselect = 1'b1; write_n = 1'b0; address = 2'd0; out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            writedata = $urandom;
            checks++; if (out_port !== exp_port()) begin errors++; $display("FAIL wrap_port got=%h exp=%h", out_port, exp_port()); end
            step();
        end
        chipselect = 1'b0; write_n = 1'b1; out_ready = 1'b0;
        bus_read(2'd0);
        checks++; if (readdata !== 32'h300) begin errors++; $display("FAIL wrap_level got=%h exp=300", readdata); end
        checks++; if (out_port !== exp_port()) begin errors++; $display("FAIL wrap_head got=%h exp=%h", out_port, exp_port()); end
    endtask

    task automatic test_flush();
        bus_write(2'd0, $urandom);
        bus_write(2'd0, $urandom);
        out_ready = 1'b1;
        bus_write(2'd1, 32'h4);
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
        checks++; if (out_port !== '0) begin errors++; $display("FAIL flush_port got=%h exp=0", out_port); end
        bus_read(2'd1);
        checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL flush_ctrl got=%h exp=0", readdata); end
        bus_read(2'd0);
        checks++; if (readdata !== 32'h1) begin errors++; $display("FAIL flush_status got=%h exp=1", readdata); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            chipselect = ($urandom_range(0, 9) < 5);
            write_n    = ($urandom_range(0, 9) < 4);
            address    = ($urandom_range(0, 9) < 6) ? 2'd0 : 2'($urandom_range(1, 3));
            writedata  = $urandom;
            if (address == 2'd1 && $urandom_range(0, 7) != 0) writedata[2] = 1'b0;
            if (address == 2'd2) writedata = $urandom_range(0, 16);
            out_ready  = ($urandom_range(0, 9) < 4);
            checks++; if (out_valid !== (mq.size() != 0)) begin errors++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", i, out_valid, mq.size() != 0); end
            checks++; if (out_port !== exp_port()) begin errors++; $display("FAIL rnd_port cyc=%0d got=%h exp=%h", i, out_port, exp_port()); end
            checks++; if (irq !== exp_irq()) begin errors++; $display("FAIL rnd_irq cyc=%0d got=%b exp=%b", i, irq, exp_irq()); end
            step();
            checks++; if (readdata !== m_rd) begin errors++; $display("FAIL rnd_readdata cyc=%0d got=%h exp=%h", i, readdata, m_rd); end
        end
        chipselect = 1'b0; write_n = 1'b1; out_ready = 1'b0;
    endtask

    task automatic test_reset_midstream();
        bus_write(2'd1, 32'h4);
        bus_write(2'd2, 32'd10);
        bus_write(2'd1, 32'h1);
        bus_write(2'd3, 32'h0);
        for (int i = 0; i < 12; i++) bus_write(2'd0, $urandom);
        out_ready = 1'b1;
        repeat (4) step();
        out_ready = 1'b0;
        step();
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL pre_reset_irq got=%b exp=1", irq); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid got=%b exp=0", out_valid); end
        checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL mid_reset_readdata got=%h exp=0", readdata); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mid_reset_irq got=%b exp=0", irq); end
        for (int a = 0; a < 4; a++) begin
            bus_read(2'(a));
            checks++; if (readdata !== ((a == 0) ? 32'h1 : 32'h0)) begin errors++; $display("FAIL mid_reset_reg%0d got=%h exp=%h", a, readdata, (a == 0) ? 32'h1 : 32'h0); end
        end
    endtask

    initial begin
        test_reset();
        test_push_basic();
        test_full();
        test_lowwater();
        test_wrap();
        test_flush();
        test_random();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/data_out_stream.md
DATA_OUT_STREAM -- requirements
Module: data_out_stream

Interface
REQ-001 SHALL have parameter DATA_W, default 16, width of each output sample.
REQ-002 SHALL have parameter DEPTH, default 16, FIFO depth in samples (power of two, 2..256).
REQ-003 SHALL have port clk, input, 1, the only clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-005 SHALL have port address, input, 2, Avalon-MM register select.
REQ-006 SHALL have port chipselect, input, 1, Avalon-MM slave select.
REQ-007 SHALL have port write_n, input, 1, active-low write strobe.
REQ-008 SHALL have port writedata, input, 32, write data.
REQ-009 SHALL have port readdata, output, 32, registered read data.
REQ-010 SHALL have port out_port, output, DATA_W, FIFO head sample (first-word fall-through).
REQ-011 SHALL have port out_valid, output, 1, high when the FIFO is not empty.
REQ-012 SHALL have port out_ready, input, 1, fabric consumer accepts out_port.
REQ-013 SHALL have port irq, output, 1, level interrupt equal to OR of (event & irq_mask).

Function
REQ-014 A write is chipselect & ~write_n; a read is every cycle with readdata <= mux(address), 1-cycle latency, upper unused bits zero.
REQ-015 Addr 0 write SHALL push writedata[DATA_W-1:0]; addr 0 read SHALL return {level[23:8], full[1], empty[0]}.
REQ-016 Addr 1 SHALL hold control: bit0 lowwater irq_mask, bit1 overflow irq_mask, bit2 flush (write-only, self-clearing, reads 0).
REQ-017 Addr 2 SHALL hold the low-watermark threshold, log2(DEPTH)+1 bits, read back as written.
REQ-018 Addr 3 read SHALL return event bits {overflow[1], lowwater[0]}; any write to addr 3 SHALL clear both.
REQ-019 Pop SHALL occur on cycles where out_valid & out_ready; out_port SHALL then present the next entry on the following cycle.
REQ-020 A push into an empty FIFO SHALL raise out_valid and present the data on the next cycle, never the same cycle.
REQ-021 Push and pop in the same cycle SHALL both occur, leaving the level unchanged; wrap-around of read/write pointers SHALL be transparent.
REQ-022 A push while full SHALL be dropped even when a pop occurs in the same cycle; the level and contents SHALL remain unchanged.
REQ-023 The lowwater event SHALL set on the cycle after the level transitions from above the threshold to at or below it; it SHALL not re-set while the level stays low.
REQ-024 When an event set and an addr-3 clear coincide, the clear SHALL win.
REQ-025 Flush SHALL empty the FIFO on the next cycle; any push or pop in the same cycle SHALL be discarded.
REQ-026 out_port SHALL be 0 while the FIFO is empty.

Reset
REQ-027 Reset SHALL clear the pointers, level (0), readdata, control, threshold (0), events, out_valid and irq to 0; FIFO storage need not be cleared.
REQ-028 Reset asserted mid-stream SHALL discard all queued samples, and out_valid SHALL be 0 on the cycle after reset is sampled.

Configuration
REQ-029 With macro DATA_OUT_STREAM_OVERFLOW_EN defined, REQ-022 drops SHALL set the overflow event.
REQ-030 Without DATA_OUT_STREAM_OVERFLOW_EN, no overflow logic SHALL exist: overflow event bit and irq_mask bit1 SHALL read 0 and be ignored, and drops SHALL remain silent.

Verification
REQ-031 Write 0x1234 to addr 0 with out_ready=0 -> out_valid=1 and out_port=0x1234 next cycle; the addr 0 read returns level 1, empty 0.
REQ-032 Push 16 samples (DEPTH 16) then one more with out_ready=0 -> full=1, 17th sample lost; with the macro defined, event bit1=1 and irq=1 once mask bit1 is set.
REQ-033 Threshold 4, mask bit0 set, FIFO at 6, out_ready=1 -> lowwater event and irq assert when level reaches 4; a write to addr 3 deasserts irq.
REQ-034 FIFO at level 3, simultaneous push and pop for 40 cycles -> level stays 3, data order preserved across pointer wrap.
REQ-035 FIFO at level 5, write control bit2 -> level 0, out_valid=0 next cycle, control reads bit2=0.
REQ-036 Assert reset for 1 cycle with level 8 -> out_valid=0, readdata=0, irq=0, all registers 0 thereafter.
